// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned UART_DEF_DIV = 16;

endpackage

// File: rtl/baud_gen.sv
// Baud tick generator: registered tick once every div_i cycles, restartable synchronously.
module baud_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // >= guards against a counter left above a freshly lowered divisor.
  assign wrap = (cnt_q >= (div_i - DIV_W'(1)));

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + DIV_W'(1);
    tick_d = wrap;
    if (srst_i) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q  <= cnt_d;
    tick_q <= tick_d;
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames bytes onto tx, sequences baud_gen and applies
// divisor updates only between frames.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DEF_DIV   = UART_DEF_DIV,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_wr,
  output logic              cfg_pend,
  output logic [DIV_W-1:0]  div_active,
  output logic [DIV_W-1:0]  bg_div,
  output logic              bg_rst,
  input  logic              bg_tick,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              cfg_pend_q, cfg_pend_d;
  logic [DIV_W-1:0]  pend_div_q, pend_div_d;
  logic [DIV_W-1:0]  div_active_q, div_active_d;
  logic              accept;
  logic              apply;

  assign tx_ready = (state_q == IDLE) && !cfg_pend_q;
  assign accept   = tx_valid && tx_ready;
  assign apply    = (state_q == IDLE) && cfg_pend_q && !accept;
  // Restart on accept so the start bit is aligned to the generator period.
  assign bg_rst   = accept || apply || !rst;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = tx_data;
          par_d   = (^tx_data) ^ (PARITY == PAR_ODD);
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bg_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      DATA: begin
        if (bg_tick) begin
          if (bit_cnt_q != LastBit) begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end else if (PARITY != PAR_NONE) begin
            state_d = PAR;
            tx_d    = par_q;
          end else begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b1;
          end
        end
      end
      PAR: begin
        if (bg_tick) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      STOP: begin
        if (bg_tick) begin
          if ((STOP_BITS == 2) && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // A write coinciding with an apply lands in the pending slot and stays pending.
  always_comb begin
    pend_div_d   = pend_div_q;
    cfg_pend_d   = cfg_pend_q;
    div_active_d = div_active_q;
    if (apply) begin
      div_active_d = pend_div_q;
      cfg_pend_d   = 1'b0;
    end
    if (cfg_wr) begin
      pend_div_d = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
      cfg_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      cfg_pend_q   <= 1'b0;
      pend_div_q   <= DIV_W'(DEF_DIV);
      div_active_q <= DIV_W'(DEF_DIV);
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      par_q        <= par_d;
      tx_q         <= tx_d;
      cfg_pend_q   <= cfg_pend_d;
      pend_div_q   <= pend_div_d;
      div_active_q <= div_active_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign cfg_pend   = cfg_pend_q;
  assign div_active = div_active_q;
  assign bg_div     = div_active_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller that owns and sequences the shared baud tick generator (baud_gen). It accepts bytes over a valid/ready handshake and serialises them as start/data/parity/stop bits, one bit per baud tick. It also manages run-time divisor changes safely: updates are applied only between frames, with a generator restart. It sits between the bus-side register block and the external baud_gen instance plus the tx pin.

Parameters:
DATA_W, 8, data bits per frame (5..8)
DIV_W, 8, divisor width; must match baud_gen div
DEF_DIV, 16, divisor loaded at reset
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
tx_data  in  DATA_W  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  controller can accept a byte
cfg_div  in  DIV_W  new baud divisor
cfg_wr  in  1  write strobe for cfg_div
cfg_pend  out  1  divisor update waiting to be applied
div_active  out  DIV_W  divisor currently in use
bg_div  out  DIV_W  divisor to baud_gen; equals div_active
bg_rst  out  1  synchronous restart to baud_gen, active-high
bg_tick  in  1  tick from baud_gen
tx  out  1  serial line, idle high
busy  out  1  frame in progress
done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (rst low, asynchronous): state IDLE; tx=1; busy=0; done=0; cfg_pend=0; div_active=DEF_DIV; bg_rst=1 for as long as rst is low.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START on accept.
  - START -> DATA on bg_tick.
  - DATA -> DATA on bg_tick while bit_cnt < DATA_W-1. Otherwise DATA -> PAR if PARITY != 0, else DATA -> STOP.
  - PAR -> STOP on bg_tick.
  - STOP -> STOP on bg_tick while stop_cnt < STOP_BITS-1. Otherwise STOP -> IDLE, with done=1 in that same cycle.
- Handshake: tx_ready = (state==IDLE) && !cfg_pend. Accept = tx_valid && tx_ready.
  - On accept: tx_data is latched into the shift register and the parity bit is computed from the latched data.
  - tx_data is not sampled after the accept cycle.
- bg_rst is combinational: (accept || apply || !rst). Restarting the generator on accept aligns bit boundaries to the frame.
- Timing:
  - tx is registered and goes low at the accept edge.
  - Start bit lasts div_active+1 cycles.
  - Every later bit lasts exactly div_active cycles.
  - Data bits are sent LSB first.
  - Parity bit: even = XOR of the data bits; odd = its inverse.
  - tx=1 in STOP and IDLE.
- busy=1 in every state except IDLE.
- Back-to-back frames: ready rises the cycle after the STOP->IDLE transition. If tx_valid is held, the next start bit begins at the following edge, giving exactly 1 idle cycle between frames.
- bg_tick in IDLE is ignored.
- Config path:
  - cfg_wr captures cfg_div into a pending register and sets cfg_pend. A value of 0 is stored as 1.
  - A second cfg_wr while pending overwrites the pending value.
  - Apply: in IDLE with cfg_pend=1 and no accept, div_active <= pending, cfg_pend <= 0, bg_rst=1 for that cycle.
  - cfg_wr and accept in the same cycle: the frame is sent with the old divisor; the new one is applied in the first IDLE cycle after the frame.
  - cfg_wr in the same cycle as an apply: the new value is captured and cfg_pend stays 1.
- Reset mid-frame: tx returns to 1 immediately and the frame is abandoned; no done pulse.
- Counters: bit_cnt is $clog2(DATA_W) bits; stop_cnt is 1 bit. Both clear on entry to their state.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_e {IDLE, START, DATA, PAR, STOP}
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD
  - default divisor constant
- No sub-module: baud_gen stays a sibling instance wired through bg_div/bg_rst/bg_tick.
- The bench instantiates uart_tx_ctrl together with baud_gen.

Test Plan:
- div=4, PARITY=0, STOP_BITS=1, send 0xA5 -> tx sequence: low 5 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles. busy high 41 cycles; done pulses once.
- PARITY=1 (even), div=2, send 0x07 -> parity bit 1, 2 cycles long. With PARITY=2 (odd): parity bit 0.
- tx_valid held high, send 0x55 then 0xAA, div=3 -> exactly 1 idle cycle between the stop bit and the second start bit; both bytes are serialised correctly.
- cfg_wr(8) mid-frame at div=4 -> frame completes at 4 cycles/bit. cfg_pend=1 and tx_ready=0 until the apply cycle (bg_rst=1). The next frame runs at 8 cycles/bit; div_active=8.
- cfg_wr(0) -> div_active=1. The next frame has a 2-cycle start bit and 1-cycle data bits.
- rst low during DATA -> tx=1 and busy=0 asynchronously. div_active=16, no done pulse, and tx_ready=1 after release.
